// File: rtl/comb_sweeper.sv
// comb_sweeper: exhaustive input sweeper for one universal-gate path of comb.
// Drives every vector of the selected gate (u21, u31, u41, u22 or the u22
// output mux), folds each response into a 16-bit MISR and counts the
// response 1 bits, so the gates can be characterised on silicon without
// software stepping every vector.
//
// Optional feature: define COMB_SWEEPER_HOLD_EN to add a 'hold' input that
// freezes a sweep in progress (vector, drives, MISR and ones count) while
// keeping busy asserted. Without the macro the sweep never stalls.
module comb_sweeper #(
    parameter int SIG_W = 16,   // MISR taps are fixed at 16'h002D: 16 only
    parameter int CNT_W = 11    // >= 11 so 1024 u41 responses cannot overflow
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
`ifdef COMB_SWEEPER_HOLD_EN
    input  logic             hold,
`endif
    input  logic [2:0]       gate_sel,
    output logic [3:0]       u21_in,
    output logic [5:0]       u31_in,
    output logic [9:0]       u41_in,
    output logic [5:0]       u22_in,
    output logic             u22_sel,
    input  logic             u21_out,
    input  logic             u31_out,
    input  logic             u41_out,
    input  logic [1:0]       u22_out,
    input  logic             mux_out,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] ones_cnt
);

    localparam logic [SIG_W-1:0] MISR_POLY = SIG_W'(16'h002D);

    localparam logic [2:0] SEL_U21 = 3'd0;
    localparam logic [2:0] SEL_U31 = 3'd1;
    localparam logic [2:0] SEL_U41 = 3'd2;
    localparam logic [2:0] SEL_U22 = 3'd3;
    localparam logic [2:0] SEL_MUX = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [2:0]         sel_q;      // target latched at the accepted start
    logic [9:0]         vec_q;      // vector currently presented to comb
    logic [SIG_W-1:0]   sig_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               error_q;

    logic               hold_w;
    logic               start_ok;
    logic               advance;
    logic               last_hit;
    logic [1:0]         resp;

    // Last vector index of the sweep for a target (2^W - 1).
    function automatic logic [9:0] last_vec(input logic [2:0] sel);
        logic [9:0] lv;
        case (sel)
            SEL_U21: lv = 10'h00F;
            SEL_U31: lv = 10'h03F;
            SEL_U41: lv = 10'h3FF;
            SEL_U22: lv = 10'h03F;
            SEL_MUX: lv = 10'h07F;
            default: lv = 10'h000;
        endcase
        return lv;
    endfunction

    function automatic logic sel_valid(input logic [2:0] sel);
        return (sel <= SEL_MUX);
    endfunction

    // One MISR step: shift, fold the feedback polynomial, inject response.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                   input logic [1:0]       r);
        logic [SIG_W-1:0] nxt;
        nxt = {sig[SIG_W-2:0], 1'b0};
        if (sig[SIG_W-1]) begin
            nxt = nxt ^ MISR_POLY;
        end
        nxt = nxt ^ {{(SIG_W-2){1'b0}}, r};
        return nxt;
    endfunction

    // Number of set bits in a 2-bit response.
    function automatic logic [1:0] popcount2(input logic [1:0] r);
        return {r[1] & r[0], r[1] ^ r[0]};
    endfunction

`ifdef COMB_SWEEPER_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    // A start is honoured only when no sweep is running.
    assign start_ok = start && (state_q != S_RUN);
    assign advance  = (state_q == S_RUN) && !hold_w;
    assign last_hit = (vec_q == last_vec(sel_q));

    // Select the response of the latched target; comb is purely combinational.
    always_comb begin
        resp = 2'b00;
        case (sel_q)
            SEL_U21: resp = {1'b0, u21_out};
            SEL_U31: resp = {1'b0, u31_out};
            SEL_U41: resp = {1'b0, u41_out};
            SEL_U22: resp = u22_out;
            SEL_MUX: resp = {1'b0, mux_out};
            default: resp = 2'b00;
        endcase
    end

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start from IDLE/DONE, finish on the last vector.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = sel_valid(gate_sel) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (advance && last_hit) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sweep datapath: latch target on start, then step vector, MISR and count.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sel_q   <= 3'd0;
            vec_q   <= 10'd0;
            sig_q   <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else if (start_ok) begin
            sel_q   <= gate_sel;
            vec_q   <= 10'd0;
            sig_q   <= '0;
            cnt_q   <= '0;
            error_q <= !sel_valid(gate_sel);
        end else if (advance) begin
            sig_q <= misr_step(sig_q, resp);
            cnt_q <= cnt_q + {{(CNT_W-2){1'b0}}, popcount2(resp)};
            // Park the counter at 0 after the last vector; no second pass.
            if (last_hit) begin
                vec_q <= 10'd0;
            end else begin
                vec_q <= vec_q + 10'd1;
            end
        end
    end

    // Outputs: status from the state, vector routed to the selected bus only.
    always_comb begin
        busy    = (state_q == S_RUN);
        done    = (state_q == S_DONE);
        u21_in  = 4'd0;
        u31_in  = 6'd0;
        u41_in  = 10'd0;
        u22_in  = 6'd0;
        u22_sel = 1'b0;
        if (state_q == S_RUN) begin
            case (sel_q)
                SEL_U21: u21_in = vec_q[3:0];
                SEL_U31: u31_in = vec_q[5:0];
                SEL_U41: u41_in = vec_q;
                SEL_U22: u22_in = vec_q[5:0];
                SEL_MUX: begin
                    u22_in  = vec_q[5:0];
                    u22_sel = vec_q[6];
                end
                default: ;
            endcase
        end
    end

    assign error     = error_q;
    assign signature = sig_q;
    assign ones_cnt  = cnt_q;

endmodule

// File: tb/tb_comb_sweeper.sv
// tb_comb_sweeper: table-driven and randomized bench for comb_sweeper.
// A behavioural comb model (random lookup tables or forced constants) answers
// the sweeper's drives; expected signatures and counts come from a reference
// sweep that walks every vector of the target with plain arithmetic.
module tb_comb_sweeper;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        start;
    logic [2:0]  gate_sel;
    logic [3:0]  u21_in;
    logic [5:0]  u31_in;
    logic [9:0]  u41_in;
    logic [5:0]  u22_in;
    logic        u22_sel;
    logic        u21_out;
    logic        u31_out;
    logic        u41_out;
    logic [1:0]  u22_out;
    logic        mux_out;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] signature;
    logic [10:0] ones_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural comb: random truth tables, or every output forced.
    logic          force_en;
    logic [1:0]    force_val;
    logic [15:0]   lut21;
    logic [63:0]   lut31;
    logic [1023:0] lut41;
    logic [127:0]  lut22;   // index {u22_in, bit}: bit 0 = out[0], bit 1 = out[1]

    logic [26:0] drv_all;
    assign drv_all = {u21_in, u31_in, u41_in, u22_in, u22_sel};

    always #5 wb_clk_i = ~wb_clk_i;

    always_comb begin
        u21_out = force_en ? force_val[0] : lut21[u21_in];
        u31_out = force_en ? force_val[0] : lut31[u31_in];
        u41_out = force_en ? force_val[0] : lut41[u41_in];
        u22_out = force_en ? force_val : {lut22[{u22_in, 1'b1}], lut22[{u22_in, 1'b0}]};
        mux_out = force_en ? force_val[0] : lut22[{u22_in, u22_sel}];
    end

    comb_sweeper dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .start     (start),
        .gate_sel  (gate_sel),
        .u21_in    (u21_in),
        .u31_in    (u31_in),
        .u41_in    (u41_in),
        .u22_in    (u22_in),
        .u22_sel   (u22_sel),
        .u21_out   (u21_out),
        .u31_out   (u31_out),
        .u41_out   (u41_out),
        .u22_out   (u22_out),
        .mux_out   (mux_out),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .signature (signature),
        .ones_cnt  (ones_cnt)
    );

    typedef struct {
        logic [2:0]  sel;
        logic        force_en;
        logic [1:0]  force_val;
        int          width;      // sweep width W, busy lasts 2^W cycles
        int          exp_ones;   // -1: take from the reference sweep
        logic        sig_known;  // 1: exp_sig is a fixed constant
        logic [15:0] exp_sig;
    } row_t;

    row_t tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int sweep_w(input int sel);
        case (sel)
            0: return 4;
            1: return 6;
            2: return 10;
            3: return 6;
            default: return 7;
        endcase
    endfunction

    // Response of the target to vector v, from the behavioural comb rules.
    function automatic logic [1:0] ref_resp(input int sel, input int v);
        logic [9:0] vv;
        vv = v[9:0];
        if (force_en) return (sel == 3) ? force_val : {1'b0, force_val[0]};
        case (sel)
            0: return {1'b0, lut21[vv[3:0]]};
            1: return {1'b0, lut31[vv[5:0]]};
            2: return {1'b0, lut41[vv]};
            3: return {lut22[{vv[5:0], 1'b1}], lut22[{vv[5:0], 1'b0}]};
            default: return {1'b0, lut22[{vv[5:0], vv[6]}]};
        endcase
    endfunction

    // Reference: walk all 2^W vectors, compress into MISR and ones count.
    task automatic ref_sweep(input int sel, output int ones, output logic [15:0] sig);
        logic [1:0] r;
        sig  = 16'h0;
        ones = 0;
        for (int v = 0; v < (1 << sweep_w(sel)); v++) begin
            r    = ref_resp(sel, v);
            sig  = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h002D : 16'h0000) ^ {14'b0, r};
            ones = ones + int'(r[0]) + int'(r[1]);
        end
    endtask

    // Expected packed drives {u21,u31,u41,u22,u22_sel} while presenting vector k.
    function automatic logic [26:0] drv_expect(input int sel, input int k);
        logic [26:0] e;
        logic [9:0]  kv;
        e  = '0;
        kv = k[9:0];
        case (sel)
            0: e[26:23] = kv[3:0];
            1: e[22:17] = kv[5:0];
            2: e[16:7]  = kv;
            3: e[6:1]   = kv[5:0];
            default: begin
                e[6:1] = kv[5:0];
                e[0]   = kv[6];
            end
        endcase
        return e;
    endfunction

    task automatic check_all_zero(input string name);
        check(name, {busy, done, error, signature, ones_cnt, drv_all}, 64'h0);
    endtask

    task automatic randomize_luts();
        lut21 = 16'($urandom);
        lut31 = {$urandom, $urandom};
        for (int i = 0; i < 32; i++) lut41[i*32 +: 32] = $urandom;
        lut22 = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Start a sweep from IDLE/DONE, follow every busy cycle, check the results.
    task automatic run_row(input row_t row, input string tag);
        int          m_ones;
        logic [15:0] m_sig;
        int          exp_ones;
        logic [15:0] exp_sig;
        int          k;
        int          bad;
        force_en  = row.force_en;
        force_val = row.force_val;
        ref_sweep(int'(row.sel), m_ones, m_sig);
        exp_ones = (row.exp_ones < 0) ? m_ones : row.exp_ones;
        exp_sig  = row.sig_known ? row.exp_sig : m_sig;
        @(negedge wb_clk_i);
        gate_sel = row.sel;
        start    = 1'b1;
        @(negedge wb_clk_i);
        start    = 1'b0;
        gate_sel = 3'd7;   // later changes must not disturb the sweep
        k   = 0;
        bad = 0;
        while (busy && k < 1100) begin
            if (drv_all !== drv_expect(int'(row.sel), k)) bad++;
            k++;
            @(negedge wb_clk_i);
        end
        check({tag, "_busy_cycles"}, 64'(k), 64'(1 << row.width));
        check({tag, "_drive_mismatches"}, 64'(bad), 64'h0);
        check({tag, "_done_error"}, {done, error}, 2'b10);
        check({tag, "_ones_cnt"}, 64'(ones_cnt), 64'(exp_ones));
        check({tag, "_signature"}, 64'(signature), 64'(exp_sig));
        check({tag, "_drives_idle"}, 64'(drv_all), 64'h0);
    endtask

    initial begin
        row_t rr;
        int   k;
        int   bad;

        //            sel   frc   val    W   ones  known sig
        tbl[0] = '{3'd0, 1'b1, 2'b01,  4,   16, 1'b1, 16'hFFFF};
        tbl[1] = '{3'd2, 1'b1, 2'b00, 10,    0, 1'b1, 16'h0000};
        tbl[2] = '{3'd3, 1'b1, 2'b11,  6,  128, 1'b0, 16'h0000};
        tbl[3] = '{3'd4, 1'b0, 2'b00,  7,   -1, 1'b0, 16'h0000};
        tbl[4] = '{3'd1, 1'b0, 2'b00,  6,   -1, 1'b0, 16'h0000};
        tbl[5] = '{3'd0, 1'b0, 2'b00,  4,   -1, 1'b0, 16'h0000};
        tbl[6] = '{3'd2, 1'b0, 2'b00, 10,   -1, 1'b0, 16'h0000};

        randomize_luts();
        force_en  = 1'b0;
        force_val = 2'b00;
        wb_rst_i  = 1'b1;
        start     = 1'b0;
        gate_sel  = 3'd0;
        repeat (3) @(negedge wb_clk_i);
        check_all_zero("reset_state");
        wb_rst_i = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_row(tbl[i], $sformatf("row%0d", i));
        end

        // Extra randomized sweeps with fresh truth tables.
        for (int i = 0; i < 4; i++) begin
            randomize_luts();
            rr.sel       = 3'($urandom_range(0, 4));
            rr.force_en  = 1'b0;
            rr.force_val = 2'b00;
            rr.width     = sweep_w(int'(rr.sel));
            rr.exp_ones  = -1;
            rr.sig_known = 1'b0;
            rr.exp_sig   = 16'h0;
            run_row(rr, $sformatf("rand%0d", i));
        end

        // Invalid selection: straight to DONE with error, no busy, results cleared.
        @(negedge wb_clk_i);
        gate_sel = 3'd5;
        start    = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        check("invalid_status", {busy, done, error}, 3'b011);
        check("invalid_results", {signature, ones_cnt, drv_all}, 64'h0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            if (busy !== 1'b0) bad++;
        end
        check("invalid_busy_never", 64'(bad), 64'h0);

        // Interference: start mid-sweep ignored, then reset mid-sweep.
        force_en  = 1'b1;
        force_val = 2'b01;
        @(negedge wb_clk_i);
        gate_sel = 3'd0;
        start    = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        k   = 0;
        bad = 0;
        while (k < 9) begin
            if (drv_all !== drv_expect(0, k) || busy !== 1'b1) bad++;
            start = (k == 5);
            k++;
            @(negedge wb_clk_i);
        end
        start = 1'b0;
        check("interf_drives_v9", 64'(drv_all), 64'(drv_expect(0, 9)));
        check("interf_start_ignored", 64'(bad), 64'h0);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        check_all_zero("interf_reset");
        wb_rst_i = 1'b0;
        run_row(tbl[0], "after_reset");

        // Reset and start together: reset wins, the start is lost.
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        start    = 1'b1;
        gate_sel = 3'd0;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        start    = 1'b0;
        check_all_zero("rst_start_same_edge");
        @(negedge wb_clk_i);
        check("rst_start_no_sweep", {busy, done}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
